// File: rtl/float32_to_recoded_float32_seq.sv
// Sequential IEEE single -> recoded single converter.
// Zero, normal, infinity and NaN operands convert in one step. Subnormal
// operands are normalised by a shift loop of one bit per cycle, decrementing
// the recoded exponent on every shift. The result register holds steady
// until the consumer takes it.
module float32_to_recoded_float32_seq #(
    parameter int EXP_BITS = 8,
    parameter int SIG_BITS = 23
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [EXP_BITS+SIG_BITS:0]   in_bits,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [EXP_BITS+SIG_BITS+1:0] out_bits
);

    // Recoded exponent encodings (9 bits when EXP_BITS is 8).
    // Normal offset and subnormal start value, 0x081.
    localparam logic [EXP_BITS:0] REXP_BIAS = {2'b01, {(EXP_BITS-2){1'b0}}, 1'b1};
    // Infinity, 0x180.
    localparam logic [EXP_BITS:0] REXP_INF  = {2'b11, {(EXP_BITS-1){1'b0}}};
    // NaN, 0x1C0.
    localparam logic [EXP_BITS:0] REXP_NAN  = {3'b111, {(EXP_BITS-2){1'b0}}};
    localparam logic [EXP_BITS:0] REXP_ZERO = {(EXP_BITS+1){1'b0}};
    localparam logic [EXP_BITS:0] REXP_ONE  = {{EXP_BITS{1'b0}}, 1'b1};
    localparam logic [SIG_BITS-1:0] FRAC_ZERO = {SIG_BITS{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [SIG_BITS-1:0]           sh_q, sh_d;
    logic [EXP_BITS:0]             cnt_q, cnt_d;
    logic                          sign_q, sign_d;
    logic [EXP_BITS+SIG_BITS+1:0]  out_q, out_d;

    // Operand field decode.
    logic                in_sign;
    logic [EXP_BITS-1:0] in_exp;
    logic [SIG_BITS-1:0] in_frac;
    logic                exp_zero;
    logic                exp_ones;
    logic                frac_nz;

    assign in_sign  = in_bits[EXP_BITS+SIG_BITS];
    assign in_exp   = in_bits[EXP_BITS+SIG_BITS-1:SIG_BITS];
    assign in_frac  = in_bits[SIG_BITS-1:0];
    assign exp_zero = ~|in_exp;
    assign exp_ones = &in_exp;
    assign frac_nz  = |in_frac;

    // Recoded exponent of a normal operand: exponent plus 0x081.
    function automatic logic [EXP_BITS:0] normal_rexp(input logic [EXP_BITS-1:0] e);
        return {1'b0, e} + REXP_BIAS;
    endfunction

    // Next-state, shift loop and result selection.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    if (exp_zero) begin
                        if (frac_nz) begin
                            sh_d    = in_frac;
                            cnt_d   = REXP_BIAS;
                            state_d = NORM;
                        end else begin
                            out_d   = {in_sign, REXP_ZERO, FRAC_ZERO};
                            state_d = DONE;
                        end
                    end else if (exp_ones) begin
                        if (frac_nz) begin
                            out_d = {in_sign, REXP_NAN, in_frac};
                        end else begin
                            out_d = {in_sign, REXP_INF, FRAC_ZERO};
                        end
                        state_d = DONE;
                    end else begin
                        out_d   = {in_sign, normal_rexp(in_exp), in_frac};
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            NORM: begin
                if (sh_q[SIG_BITS-1]) begin
                    // Leading one becomes implicit; drop it and shift once more.
                    out_d   = {sign_q, cnt_q, sh_q[SIG_BITS-2:0], 1'b0};
                    state_d = DONE;
                end else begin
                    sh_d    = sh_q << 1;
                    cnt_d   = cnt_q - REXP_ONE;
                    state_d = NORM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= FRAC_ZERO;
            cnt_q   <= REXP_ZERO;
            sign_q  <= 1'b0;
            out_q   <= {(EXP_BITS+SIG_BITS+2){1'b0}};
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bits  = out_q;

endmodule

// File: tb/tb_float32_to_recoded_float32_seq.sv
// Self-checking bench for float32_to_recoded_float32_seq: directed corner
// operands, backpressure, reset mid-operation and randomized operands,
// all compared against an arithmetic reference model.
module tb_float32_to_recoded_float32_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_bits = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [32:0] out_bits;

    int checks = 0;
    int errors = 0;

    float32_to_recoded_float32_seq #(.EXP_BITS(8), .SIG_BITS(23)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: value-level recoding with a leading-zero count for subnormals.
    task automatic ref_conv(input logic [31:0] x, output logic [32:0] r, output int lat);
        int s, e, f, k, rexp, fr;
        s = int'(x[31]);
        e = int'(x[30:23]);
        f = int'(x[22:0]);
        lat = 1;
        if (e == 0 && f == 0) begin
            rexp = 0; fr = 0;
        end else if (e == 0) begin
            k = 0;
            while ((f & (1 << (22 - k))) == 0) k++;
            rexp = 129 - k;
            fr   = (f << (k + 1)) & 32'h007F_FFFF;
            lat  = k + 2;
        end else if (e == 255) begin
            rexp = (f == 0) ? 384 : 448;
            fr   = f;
        end else begin
            rexp = e + 129;
            fr   = f;
        end
        r = {s[0], rexp[8:0], fr[22:0]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, wait, optional backpressure, release.
    task automatic run_op(input logic [31:0] x, input int hold, input logic [31:0] noise);
        logic [32:0] e_out;
        int e_lat, lat;
        ref_conv(x, e_out, e_lat);
        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
        out_ready = (hold == 0);
        in_bits   = x;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        in_bits  = noise;
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
            step();
            lat++;
        end
        chk("out_valid", {63'd0, out_valid}, 64'd1);
        chk("latency", 64'(lat), 64'(e_lat));
        chk("out_bits", {31'd0, out_bits}, {31'd0, e_out});
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_bits  = noise;
            step();
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_bits", {31'd0, out_bits}, {31'd0, e_out});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("ret_ready", {63'd0, in_ready}, 64'd1);
        chk("ret_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        logic [32:0] tmp_out;
        int tmp_lat;
        int seen;
        logic [31:0] x;

        // Reset state.
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_bits", {31'd0, out_bits}, 64'd0);

        // Model sanity against known encodings.
        ref_conv(32'h3F80_0000, tmp_out, tmp_lat);
        chk("model_one", {31'd0, tmp_out}, 64'h0_8000_0000);

        // Directed corner operands.
        run_op(32'h3F80_0000, 0, 32'h0);
        step();
        run_op(32'h0000_0000, 0, 32'h1234_5678);
        run_op(32'h8000_0000, 0, 32'h0);
        run_op(32'h0000_0001, 0, 32'hFFFF_FFFF);
        run_op(32'h007F_FFFF, 0, 32'h0);
        run_op(32'h7F80_0000, 0, 32'h0);
        run_op(32'h7FC0_0000, 0, 32'h0);
        run_op(32'hFF80_0001, 0, 32'h0);
        run_op(32'h7F7F_FFFF, 0, 32'h0);
        run_op(32'h0080_0000, 0, 32'h0);
        run_op(32'h8040_0000, 0, 32'h0);

        // Backpressure with new operands offered while holding.
        run_op(32'hC049_0FDB, 5, 32'h3F80_0000);
        run_op(32'h0000_0100, 5, 32'h7FC0_0000);

        // Reset in the middle of normalisation.
        in_bits  = 32'h0000_0001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("norm_busy", {63'd0, in_ready}, 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_bits", {31'd0, out_bits}, 64'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (out_valid) seen++;
        end
        chk("no_stale_valid", 64'(seen), 64'd0);
        run_op(32'h3F80_0000, 0, 32'h0);

        // Reset while holding a result in DONE.
        out_ready = 1'b0;
        in_bits   = 32'h4000_0000;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        chk("done_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("done_rst_ready", {63'd0, in_ready}, 64'd1);

        // Randomized operands weighted across classes.
        for (int n = 0; n < 60; n++) begin
            x = $urandom;
            case ($urandom_range(0, 4))
                0: x[30:23] = 8'h00;
                1: x[30:23] = 8'hFF;
                2: begin x[30:23] = 8'h00; x[22:0] = 23'(1) << $urandom_range(0, 22); end
                default: x = x;
            endcase
            run_op(x, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
